// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Purpose  : Shared definitions for the APB register-file completer: FSM
//            state encoding, response codes and bus width constants.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 32;

  // pslverr values
  localparam logic APB_OK  = 1'b0;
  localparam logic APB_ERR = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_slv_state_t;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_addr_decode.sv
`default_nettype none
// ============================================================================
// Module   : apb_addr_decode
// Purpose  : Combinational decode of a latched APB byte address into a
//            register index, a window hit flag and an error flag.
// Ports    : addr  - latched byte address
//            write - latched write flag
//            index - word index inside the register window
//            hit   - aligned address inside the window
//            error - miss, or write to the read-only register 0
// Revision : 1.0 - initial release
// ============================================================================
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                    NUM_REGS  = 8,
  parameter int                    IDX_W     = $clog2(NUM_REGS)
) (
  input  logic [APB_ADDR_W-1:0] addr,
  input  logic                  write,
  output logic [IDX_W-1:0]      index,
  output logic                  hit,
  output logic                  error
);

  localparam logic [APB_ADDR_W-1:0] c_win_bytes = APB_ADDR_W'(4 * NUM_REGS);

  logic [APB_ADDR_W-1:0] w_offset;
  logic                  w_below;
  logic                  w_misalign;
  logic                  w_over;

  // An address below the base wraps to a huge offset; w_below is still kept
  // explicit so the miss does not depend on that wrap.
  assign w_offset   = addr - BASE_ADDR;
  assign w_below    = (addr < BASE_ADDR);
  assign w_misalign = |addr[1:0];
  assign w_over     = (w_offset >= c_win_bytes);

  assign index = w_offset[2 +: IDX_W];
  assign hit   = !(w_below || w_misalign || w_over);
  assign error = !hit || (write && (index == '0));

endmodule : apb_addr_decode
`default_nettype wire

// File: rtl/apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : apb_regfile_slave
// Purpose  : APB completer exposing NUM_REGS 32-bit registers. Register 0 is
//            a read-only ID; the rest are read/write. Transfers are captured
//            in the setup phase and decoded from the captured address only.
//            Optional wait states are enabled by the macro APB_SLV_WAIT_EN.
// Ports    : hclk, hreset (sync, active low)
//            pselx, penable, pwrite, paddr, pwdata - APB requester side
//            prdata, pready, pslverr               - APB response
//            regs_q - flat register contents, register i at [32*i +: 32]
// Revision : 1.0 - initial release
// ============================================================================
module apb_regfile_slave
  import apb_pkg::*;
#(
  parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                    NUM_REGS    = 8,
  parameter logic [APB_DATA_W-1:0] ID_VALUE    = 32'hA0B1_0001,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                           hclk,
  input  logic                           hreset,
  input  logic                           pselx,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [APB_ADDR_W-1:0]          paddr,
  input  logic [APB_DATA_W-1:0]          pwdata,
  output logic [APB_DATA_W-1:0]          prdata,
  output logic                           pready,
  output logic                           pslverr,
  output logic [NUM_REGS*APB_DATA_W-1:0] regs_q
);

  localparam int         c_idx_w     = $clog2(NUM_REGS);
  localparam logic [3:0] c_wait_init = (WAIT_CYCLES > 15) ? 4'd15 : 4'(WAIT_CYCLES);

  apb_slv_state_t        r_state;
  apb_slv_state_t        w_state_nxt;
  logic [APB_ADDR_W-1:0] r_addr;
  logic [APB_DATA_W-1:0] r_wdata;
  logic                  r_write;
  logic [c_idx_w-1:0]    w_idx;
  logic                  w_hit;
  logic                  w_err;
  logic                  w_cnt_done;
  logic                  w_setup;
  logic                  w_commit;
  logic                  w_wr_en;
  logic [APB_DATA_W-1:0] w_words [NUM_REGS];

  // penable without a preceding setup phase is not a setup and is ignored.
  assign w_setup  = (r_state == ST_IDLE) && pselx && !penable;
  assign w_commit = (r_state == ST_ACCESS) && pselx && penable && w_cnt_done;
  assign w_wr_en  = w_commit && r_write && w_hit && !w_err;

  // --------------------------------------------------------------------------
  // Setup-phase capture: everything after this point decodes the copies.
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (!hreset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_setup) begin
      r_addr  <= paddr;
      r_wdata <= pwdata;
      r_write <= pwrite;
    end
  end

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (c_idx_w)
  ) u_decode (
    .addr  (r_addr),
    .write (r_write),
    .index (w_idx),
    .hit   (w_hit),
    .error (w_err)
  );

  // --------------------------------------------------------------------------
  // Wait-state counter (saturates at zero, reloaded on every setup)
  // --------------------------------------------------------------------------
`ifdef APB_SLV_WAIT_EN
  logic [3:0] r_wait_cnt;

  always_ff @(posedge hclk) begin
    if (!hreset) begin
      r_wait_cnt <= 4'd0;
    end else if (w_setup) begin
      r_wait_cnt <= c_wait_init;
    end else if ((r_state == ST_ACCESS) && (r_wait_cnt != 4'd0)) begin
      r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  assign w_cnt_done = (r_wait_cnt == 4'd0);
`else
  logic w_unused_wait;

  assign w_cnt_done    = 1'b1;
  assign w_unused_wait = ^c_wait_init;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk) begin
    if (!hreset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Dropping pselx mid-transfer aborts without a response.
        if (!pselx) begin
          w_state_nxt = ST_IDLE;
        end else if (penable && w_cnt_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    pready  = 1'b0;
    pslverr = APB_OK;
    prdata  = '0;
    if ((r_state == ST_ACCESS) && w_cnt_done) begin
      pready  = 1'b1;
      pslverr = w_err ? APB_ERR : APB_OK;
      if (!w_err && !r_write) begin
        prdata = w_words[w_idx];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Register bank; word 0 is the constant ID
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_id
      assign w_words[gi] = ID_VALUE;
    end else begin : g_rw
      logic [APB_DATA_W-1:0] r_q;

      always_ff @(posedge hclk) begin
        if (!hreset) begin
          r_q <= '0;
        end else if (w_wr_en && (w_idx == c_idx_w'(gi))) begin
          r_q <= r_wdata;
        end
      end

      assign w_words[gi] = r_q;
    end
    assign regs_q[APB_DATA_W*gi +: APB_DATA_W] = w_words[gi];
  end

endmodule : apb_regfile_slave
`default_nettype wire

// File: tb/tb_apb_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_regfile_slave
// Purpose  : Self-checking bench for apb_regfile_slave. A vector table plus
//            hand-written sequences for wait states, address changes during
//            the wait, back-to-back transfers, abort and reset mid-transfer.
//            Builds with or without APB_SLV_WAIT_EN (WAIT_CYCLES = 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_slave;

  localparam int          c_nregs = 8;
  localparam logic [31:0] c_id    = 32'hA0B1_0001;
`ifdef APB_SLV_WAIT_EN
  localparam int          c_wait  = 3;
`else
  localparam int          c_wait  = 0;
`endif

  logic                   hclk;
  logic                   hreset;
  logic                   pselx;
  logic                   penable;
  logic                   pwrite;
  logic [31:0]            paddr;
  logic [31:0]            pwdata;
  logic [31:0]            prdata;
  logic                   pready;
  logic                   pslverr;
  logic [c_nregs*32-1:0]  regs_q;

  apb_regfile_slave #(
    .BASE_ADDR   (32'h0000_0000),
    .NUM_REGS    (c_nregs),
    .ID_VALUE    (c_id),
    .WAIT_CYCLES (3)
  ) dut (
    .hclk    (hclk),
    .hreset  (hreset),
    .pselx   (pselx),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .regs_q  (regs_q)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  vec_t        vecs [10];
  resp_t       sb_q [$];
  logic [31:0] model [c_nregs];
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < c_nregs; i++) begin
      chk($sformatf("%s regs_q[%0d]", tag, i), 64'(regs_q[32*i +: 32]),
          64'((i == 0) ? c_id : model[i]));
    end
  endtask

  // One full APB transfer starting 1 time unit after a rising edge. The
  // expected response is queued at setup and retired when pready appears.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic exp_err, input logic [31:0] exp_rd, input logic scramble);
    int    start;
    int    n;
    resp_t e;
    start   = cyc;
    pselx   = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    sb_q.push_back('{err: exp_err, rdata: exp_rd});
    @(posedge hclk); #1;
    penable = 1'b1;
    if (scramble) begin
      paddr  = 32'h0000_0008;
      pwdata = 32'hFFFF_FFFF;
    end
    n = 0;
    while (!pready && n < 40) begin
      @(posedge hclk); #1;
      n++;
    end
    e = sb_q.pop_front();
    if (!pready) begin
      chk($sformatf("timeout addr %0h", addr), 64'(pready), 64'd1);
    end else begin
      chk($sformatf("latency addr %0h", addr), 64'(n), 64'(c_wait));
      chk($sformatf("pslverr addr %0h", addr), 64'(pslverr), 64'(e.err));
      chk($sformatf("prdata addr %0h", addr), 64'(prdata), 64'(e.rdata));
    end
    @(posedge hclk); #1;
    pselx   = 1'b0;
    penable = 1'b0;
    chk($sformatf("cycles addr %0h", addr), 64'(cyc - start), 64'(2 + c_wait));
    if (wr && !exp_err) model[addr[4:2]] = data;
    chk_regs($sformatf("after %0h", addr));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    vecs[0] = '{1'b0, 32'h00, 32'h0,         1'b0, c_id};
    vecs[1] = '{1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h08, 32'h0,         1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 32'h00, 32'h1234_0000, 1'b1, 32'h0};
    vecs[4] = '{1'b0, 32'h20, 32'h0,         1'b1, 32'h0};
    vecs[5] = '{1'b0, 32'h06, 32'h0,         1'b1, 32'h0};
    vecs[6] = '{1'b1, 32'h06, 32'hCAFE_F00D, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 32'h1C, 32'h1234_5678, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 32'h1C, 32'h0,         1'b0, 32'h1234_5678};
    vecs[9] = '{1'b0, 32'h04, 32'h0,         1'b0, 32'h0};
    for (int i = 0; i < c_nregs; i++) model[i] = 32'h0;

    hreset  = 1'b0;
    pselx   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 32'h0;
    pwdata  = 32'h0;
    repeat (3) @(posedge hclk);
    #1;
    chk("reset pready", 64'(pready), 64'd0);
    chk("reset pslverr", 64'(pslverr), 64'd0);
    chk("reset prdata", 64'(prdata), 64'd0);
    chk_regs("reset");
    hreset = 1'b1;
    @(posedge hclk); #1;

    for (int i = 0; i < 10; i++) begin
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rdata, 1'b0);
    end

    // Address/data change after setup must not affect the decode.
    do_xfer(1'b1, 32'h04, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, 32'h1111_1111, 1'b1);

    // Back-to-back write then read of the same register.
    do_xfer(1'b1, 32'h04, 32'h1, 1'b0, 32'h0, 1'b0);
    do_xfer(1'b0, 32'h04, 32'h0, 1'b0, 32'h1, 1'b0);

    // Abort: setup of a write, then pselx dropped in ACCESS.
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h99;
    @(posedge hclk); #1;
    pselx = 1'b0; penable = 1'b0;
    @(posedge hclk); #1;
    chk("abort pready", 64'(pready), 64'd0);
    // penable without setup while idle gets no response.
    pselx = 1'b1; penable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge hclk); #1;
      chk($sformatf("no-setup pready %0d", k), 64'(pready), 64'd0);
    end
    pselx = 1'b0; penable = 1'b0;
    chk_regs("abort");
    do_xfer(1'b0, 32'h0C, 32'h0, 1'b0, 32'h0, 1'b0);

    // Reset on the completing edge of a write drops it.
    do_xfer(1'b1, 32'h0C, 32'h77, 1'b0, 32'h0, 1'b0);
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h55;
    @(posedge hclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready && n < 40) begin
      @(posedge hclk); #1;
      n++;
    end
    chk("pre-reset pready", 64'(pready), 64'd1);
    hreset = 1'b0;
    @(posedge hclk); #1;
    pselx = 1'b0; penable = 1'b0;
    chk("reset-edge pready", 64'(pready), 64'd0);
    chk("reset-edge reg3", 64'(regs_q[127:96]), 64'd0);
    for (int i = 0; i < c_nregs; i++) model[i] = 32'h0;
    chk_regs("reset-edge");
    hreset = 1'b1;
    @(posedge hclk); #1;
    do_xfer(1'b0, 32'h08, 32'h0, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_apb_regfile_slave
`default_nettype wire
